// File: rtl/gv_pkg.sv
// Shared types and default constants for the Guitar Villains button conditioner.
// Used by: gv_debounce, gv_button_conditioner_if, gv_button_conditioner.
package gv_pkg;

  localparam int unsigned GV_NUM_BTN         = 4;
  // 5 ms at 10 MHz.
  localparam int unsigned GV_DEBOUNCE_CYCLES = 50000;
  // Auto-repeat timing. Only used when GV_BTN_AUTOREPEAT_EN is defined.
  localparam int unsigned GV_HOLD_CYCLES     = 2000000;
  localparam int unsigned GV_REPEAT_CYCLES   = 500000;

  typedef logic [1:0] gv_btn_idx_t;

  typedef enum logic {
    GV_EVT_IDLE,
    GV_EVT_PRESENT
  } gv_evt_state_t;

endpackage

// File: rtl/gv_button_conditioner_if.sv
// Press-event handshake between the button conditioner and the game FSM.
//   evt_valid : press event available (producer -> consumer)
//   evt_btn   : index of the pressed button, stable while evt_valid
//   evt_ready : consumer accepts the event (consumer -> producer)
// master = event producer (conditioner), slave = event consumer (game FSM).
interface gv_button_conditioner_if
  import gv_pkg::*;
#(
  parameter int unsigned NUM_BTN = GV_NUM_BTN
);
  localparam int unsigned IdxW = $clog2(NUM_BTN);

  logic            evt_valid;
  logic [IdxW-1:0] evt_btn;
  logic            evt_ready;

  modport master (output evt_valid, output evt_btn, input evt_ready);
  modport slave  (input evt_valid, input evt_btn, output evt_ready);

endinterface

// File: rtl/gv_debounce.sv
// One button channel: 2-flop synchronizer, counter-based debouncer and press detector.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   btn_raw  : asynchronous button pin, active high
//   stable   : registered debounced level
//   press    : one-cycle pulse, high the cycle after stable rises (plus synthetic
//              auto-repeat pulses when GV_BTN_AUTOREPEAT_EN is defined)
// Optional feature macro: GV_BTN_AUTOREPEAT_EN.
module gv_debounce
  import gv_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = GV_DEBOUNCE_CYCLES,
  parameter int unsigned HOLD_CYCLES     = GV_HOLD_CYCLES,
  parameter int unsigned REPEAT_CYCLES   = GV_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic stable,
  output logic press
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q, sync2_q;
  logic [CntW-1:0] cnt_q;
  logic            stable_q;
  logic            rise_q;
  logic            flip;

  // Level accepted this cycle: disagreement has persisted DEBOUNCE_CYCLES cycles.
  assign flip = (sync2_q != stable_q) && (cnt_q == CntLast);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      rise_q  <= flip && sync2_q;
      if (flip) begin
        stable_q <= sync2_q;
        cnt_q    <= '0;
      end else if (sync2_q != stable_q) begin
        cnt_q <= cnt_q + 1'b1;
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign stable = stable_q;

`ifdef GV_BTN_AUTOREPEAT_EN
  localparam int unsigned HoldW = $clog2(HOLD_CYCLES);
  localparam logic [HoldW-1:0] HoldLast    = HoldW'(HOLD_CYCLES - 1);
  // Rewinding to HOLD-REPEAT after each fire makes later fires REPEAT_CYCLES apart
  // (assumes REPEAT_CYCLES <= HOLD_CYCLES).
  localparam logic [HoldW-1:0] HoldRewind  = HoldW'(HOLD_CYCLES - REPEAT_CYCLES);

  logic [HoldW-1:0] hold_q;
  logic             rep_q;

  always_ff @(posedge clk) begin
    // A falling flip means release is being accepted now; never fire on that edge.
    if (rst || !stable_q || flip) begin
      hold_q <= '0;
      rep_q  <= 1'b0;
    end else if (hold_q == HoldLast) begin
      hold_q <= HoldRewind;
      rep_q  <= 1'b1;
    end else begin
      hold_q <= hold_q + 1'b1;
      rep_q  <= 1'b0;
    end
  end

  assign press = rise_q | rep_q;
`else
  assign press = rise_q;
`endif

endmodule

// File: rtl/gv_button_conditioner.sv
// Guitar Villains button conditioner: synchronizes and debounces the fret/strum
// buttons and delivers press events one at a time over a valid/ready handshake.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   ncs       : chip select, active low; high blocks new presses
//   btn_raw   : asynchronous button pins, active high
//   btn_held  : debounced button levels
//   evt       : event handshake (master side: evt_valid, evt_btn out; evt_ready in)
//   overrun   : sticky, a press hit a button whose event was still pending/presented
// Optional feature macro: GV_BTN_AUTOREPEAT_EN (hold-to-repeat synthetic presses).
module gv_button_conditioner
  import gv_pkg::*;
#(
  parameter int unsigned NUM_BTN         = GV_NUM_BTN,
  parameter int unsigned DEBOUNCE_CYCLES = GV_DEBOUNCE_CYCLES,
  parameter int unsigned HOLD_CYCLES     = GV_HOLD_CYCLES,
  parameter int unsigned REPEAT_CYCLES   = GV_REPEAT_CYCLES
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ncs,
  input  logic [NUM_BTN-1:0]       btn_raw,
  output logic [NUM_BTN-1:0]       btn_held,
  gv_button_conditioner_if.master  evt,
  output logic                     overrun
);

  localparam int unsigned IdxW = $clog2(NUM_BTN);

  logic [NUM_BTN-1:0] press;
  logic [NUM_BTN-1:0] accept, collide, presented, grant;
  logic [NUM_BTN-1:0] pending_q, pending_d;
  logic               valid_q, valid_d;
  logic [IdxW-1:0]    btn_q, btn_d;
  logic               overrun_q, overrun_d;
  gv_evt_state_t      state_q, state_d;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    gv_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLD_CYCLES     (HOLD_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_debounce (
      .clk     (clk),
      .rst     (rst),
      .btn_raw (btn_raw[g]),
      .stable  (btn_held[g]),
      .press   (press[g])
    );
  end

  always_comb begin
    presented = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      presented[i] = valid_q && (btn_q == IdxW'(i));
    end
    accept  = press & {NUM_BTN{~ncs}};
    // Presses that would stack onto an undelivered event are dropped and flagged.
    collide = accept & (pending_q | presented);
  end

  always_comb begin
    logic found;
    state_d = state_q;
    valid_d = valid_q;
    btn_d   = btn_q;
    grant   = '0;
    found   = 1'b0;
    unique case (state_q)
      GV_EVT_IDLE: begin
        if (|pending_q) begin
          for (int i = 0; i < NUM_BTN; i++) begin
            if (pending_q[i] && !found) begin
              found    = 1'b1;
              grant[i] = 1'b1;
              btn_d    = IdxW'(i);
            end
          end
          valid_d = 1'b1;
          state_d = GV_EVT_PRESENT;
        end
      end
      GV_EVT_PRESENT: begin
        if (evt.evt_ready) begin
          valid_d = 1'b0;
          state_d = GV_EVT_IDLE;
        end
      end
      default: state_d = GV_EVT_IDLE;
    endcase
    pending_d = (pending_q & ~grant) | (accept & ~collide);
    overrun_d = overrun_q | (|collide);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= GV_EVT_IDLE;
      pending_q <= '0;
      valid_q   <= 1'b0;
      btn_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      valid_q   <= valid_d;
      btn_q     <= btn_d;
      overrun_q <= overrun_d;
    end
  end

  assign evt.evt_valid = valid_q;
  assign evt.evt_btn   = btn_q;
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_gv_button_conditioner.sv
// Directed bench for gv_button_conditioner with DEBOUNCE=8, HOLD=40, REPEAT=16.
module tb_gv_button_conditioner;
  import gv_pkg::*;

  localparam int unsigned NB   = 4;
  localparam int unsigned DEB  = 8;
  localparam int unsigned HOLD = 40;
  localparam int unsigned REP  = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          ncs;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] btn_held;
  logic          overrun;

  gv_button_conditioner_if #(.NUM_BTN(NB)) evt_if ();

  gv_button_conditioner #(
    .NUM_BTN         (NB),
    .DEBOUNCE_CYCLES (DEB),
    .HOLD_CYCLES     (HOLD),
    .REPEAT_CYCLES   (REP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ncs      (ncs),
    .btn_raw  (btn_raw),
    .btn_held (btn_held),
    .evt      (evt_if),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int ev_idx[$];
  int ev_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Log every handshake; sampled mid-cycle, accepted at the following edge.
  always @(negedge clk) begin
    if (!rst && evt_if.evt_valid && evt_if.evt_ready) begin
      ev_idx.push_back(int'(evt_if.evt_btn));
      ev_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int idx_at(input int k);
    return (ev_idx.size() > k) ? ev_idx[k] : -1;
  endfunction

  function automatic int cyc_at(input int k);
    return (ev_cyc.size() > k) ? ev_cyc[k] : -1000;
  endfunction

  task automatic clear_log();
    ev_idx.delete();
    ev_cyc.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    int   rise_cyc;
    rst              = 1'b1;
    ncs              = 1'b0;
    btn_raw          = 4'hF;
    evt_if.evt_ready = 1'b0;

    // Reset with all buttons pressed.
    tick(3);
    check("rst_held", btn_held, 4'h0);
    check("rst_valid", evt_if.evt_valid, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    rst = 1'b0;
    tick(9);
    check("held_edge9", btn_held, 4'h0);
    tick(1);
    check("held_edge10", btn_held, 4'hF);
    tick(1);
    check("valid_edge11", evt_if.evt_valid, 1'b0);
    tick(1);
    check("valid_edge12", evt_if.evt_valid, 1'b1);
    check("first_btn", evt_if.evt_btn, 2'd0);
    tick(3);
    check("bp_valid", evt_if.evt_valid, 1'b1);
    check("bp_btn", evt_if.evt_btn, 2'd0);
    clear_log();
    evt_if.evt_ready = 1'b1;
    tick(12);
    btn_raw = 4'h0;
    check("drain_count", ev_idx.size(), 4);
    for (int i = 0; i < 4; i++) check("drain_order", idx_at(i), i);
    check("drain_spacing", cyc_at(2) - cyc_at(1), 2);
    tick(20);

    // Glitch rejection: 7-cycle pulse never accepted.
    clear_log();
    seen    = 1'b0;
    btn_raw = 4'b0100;
    for (int i = 0; i < 7; i++) begin
      tick(1);
      seen |= btn_held[2];
    end
    btn_raw = 4'h0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      seen |= btn_held[2];
    end
    check("glitch_held", seen, 1'b0);
    check("glitch_events", ev_idx.size(), 0);
    // 8-cycle pulse is accepted once.
    btn_raw = 4'b0100;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      seen |= btn_held[2];
    end
    btn_raw = 4'h0;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      seen |= btn_held[2];
    end
    check("pulse8_held", seen, 1'b1);
    check("pulse8_events", ev_idx.size(), 1);
    check("pulse8_btn", idx_at(0), 2);

    // Simultaneous press of buttons 1 and 3.
    clear_log();
    btn_raw = 4'b1010;
    tick(20);
    btn_raw = 4'h0;
    tick(20);
    check("simul_count", ev_idx.size(), 2);
    check("simul_first", idx_at(0), 1);
    check("simul_second", idx_at(1), 3);
    check("simul_spacing", cyc_at(1) - cyc_at(0), 2);
    check("simul_overrun", overrun, 1'b0);

    // Backpressure: second press of the presented button overruns.
    clear_log();
    evt_if.evt_ready = 1'b0;
    btn_raw = 4'b0001;
    tick(12);
    check("bp1_valid", evt_if.evt_valid, 1'b1);
    btn_raw = 4'h0;
    tick(12);
    btn_raw = 4'b0001;
    tick(12);
    check("ovr_flag", overrun, 1'b1);
    check("ovr_valid", evt_if.evt_valid, 1'b1);
    check("ovr_btn", evt_if.evt_btn, 2'd0);
    btn_raw = 4'h0;
    evt_if.evt_ready = 1'b1;
    tick(15);
    check("ovr_events", ev_idx.size(), 1);
    check("ovr_event_btn", idx_at(0), 0);
    check("ovr_sticky", overrun, 1'b1);

    // Reset mid-handshake drops the event and clears overrun.
    clear_log();
    evt_if.evt_ready = 1'b0;
    btn_raw = 4'b0010;
    tick(12);
    check("mid_valid", evt_if.evt_valid, 1'b1);
    check("mid_btn", evt_if.evt_btn, 2'd1);
    btn_raw = 4'h0;
    rst     = 1'b1;
    tick(1);
    check("mid_rst_valid", evt_if.evt_valid, 1'b0);
    check("mid_rst_btn", evt_if.evt_btn, 2'd0);
    check("mid_rst_overrun", overrun, 1'b0);
    check("mid_rst_held", btn_held, 4'h0);
    rst = 1'b0;
    evt_if.evt_ready = 1'b1;
    tick(20);
    check("mid_no_events", ev_idx.size(), 0);

    // ncs gating: debounce still runs, no event, no late event.
    clear_log();
    ncs     = 1'b1;
    btn_raw = 4'b1000;
    tick(14);
    check("ncs_held", btn_held[3], 1'b1);
    check("ncs_events", ev_idx.size(), 0);
    ncs = 1'b0;
    tick(10);
    check("ncs_late_events", ev_idx.size(), 0);
    btn_raw = 4'h0;
    tick(15);
    check("ncs_release", btn_held, 4'h0);

`ifdef GV_BTN_AUTOREPEAT_EN
    // Auto-repeat: held 100 cycles -> events at rise+0, +40, +56, +72, +88
    // (each handshake logged 2 cycles after its trigger).
    clear_log();
    rise_cyc = -1;
    btn_raw  = 4'b0010;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (rise_cyc < 0 && btn_held[1]) rise_cyc = cyc;
    end
    btn_raw = 4'h0;
    tick(60);
    check("rep_count", ev_idx.size(), 5);
    check("rep_off0", cyc_at(0) - rise_cyc, 2);
    check("rep_off1", cyc_at(1) - rise_cyc, 42);
    check("rep_off2", cyc_at(2) - rise_cyc, 58);
    check("rep_off3", cyc_at(3) - rise_cyc, 74);
    check("rep_off4", cyc_at(4) - rise_cyc, 90);
    check("rep_btn", idx_at(4), 1);
`else
    rise_cyc = 0;
    seen     = (rise_cyc != 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gv_button_conditioner.md
Name: gv_button_conditioner

Overview:
- Input-side counterpart of the Guitar Villains display/top-level pin interface.
- Takes the 4 raw fret/strum buttons from gpio_in[3:0].
- Synchronizes and debounces each button, then detects presses.
- Delivers one press event at a time to the game FSM over a valid/ready handshake; also exports debounced held levels and a sticky overrun flag.

Parameters:
- NUM_BTN, 4, number of buttons (event index width = $clog2(NUM_BTN)).
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles needed to accept a new level (5 ms at 10 MHz); minimum 2.
- HOLD_CYCLES, 2000000, hold time before auto-repeat starts (optional feature only).
- REPEAT_CYCLES, 500000, auto-repeat period (optional feature only).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- ncs  input  1  chip select, active low; when high, no new presses are accepted.
- btn_raw  input  NUM_BTN  asynchronous button pins, active high.
- btn_held  output  NUM_BTN  debounced button levels.
- evt_valid  output  1  press event available.
- evt_btn  output  $clog2(NUM_BTN)  index of pressed button; stable while evt_valid.
- evt_ready  input  1  consumer accepts the event.
- overrun  output  1  sticky: a press arrived for a button whose event was still pending.

Behaviour:
- Reset (rst high at a clk edge) clears:
  - sync flops, debounce counters and stable levels;
  - pending bits, evt_valid, evt_btn and overrun (all 0);
  - the state machine returns to IDLE.
- Reset mid-handshake drops the event and all pending presses.
- Synchronizer: 2 flops per button. Sync output = btn_raw delayed 2 cycles.
- Debounce, per button:
  - If sync != stable, the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 with sync still != stable, stable <= sync and the counter clears.
  - Any cycle with sync == stable clears the counter.
  - Glitches shorter than DEBOUNCE_CYCLES never change stable.
  - Latency from a clean raw edge to btn_held = 2 + DEBOUNCE_CYCLES cycles.
  - Counter width is $clog2(DEBOUNCE_CYCLES); the counter must not wrap.
- btn_held = stable levels (registered).
- Press detect: a stable 0->1 transition with ncs=0 sets pending[i].
  - If pending[i] is already set, or button i is the event currently presented, set overrun=1; the press is dropped.
  - Releases generate no event. ncs=1 suppresses detection only; debounce continues and already-pending events still deliver.
- Event FSM, registered outputs:
  - IDLE: if pending != 0, evt_btn <= lowest set index, evt_valid <= 1, that pending bit clears, go PRESENT.
  - PRESENT: hold evt_btn/evt_valid until evt_ready=1. On the valid&ready edge, evt_valid <= 0 and go IDLE.
  - One bubble cycle per event: max throughput is 1 event per 2 cycles.
- Simultaneous presses: all pending bits set in the same cycle; delivered lowest index first.
- A new press of the presented button while in PRESENT counts as overrun, even if evt_ready is high that same cycle.
- evt_ready while evt_valid=0 is ignored.

Optional Feature:
- Macro: GV_BTN_AUTOREPEAT_EN.
- Defined: a per-button hold counter runs while stable=1.
  - After HOLD_CYCLES it raises a synthetic press (same path as a real press, including overrun rules).
  - It then raises another every REPEAT_CYCLES until release.
  - Release or rst clears the hold counter.
- Not defined: no hold counters; only real 0->1 edges create events; HOLD_CYCLES/REPEAT_CYCLES are unused.

Decomposition:
- Package gv_pkg holds:
  - GV_NUM_BTN = 4;
  - typedef gv_btn_idx_t (logic [1:0]);
  - typedef enum gv_evt_state_t {GV_EVT_IDLE, GV_EVT_PRESENT};
  - the default debounce/hold/repeat constants.
- Sub-module gv_debounce: one sync+debounce channel, instantiated NUM_BTN times by generate. It outputs stable and a rise pulse.
- Arbitration, pending bits and FSM stay in the top module.

Test Plan (DEBOUNCE_CYCLES=8, HOLD_CYCLES=40, REPEAT_CYCLES=16):
- Reset: assert rst 3 cycles with btn_raw=4'hF -> btn_held=0, evt_valid=0, overrun=0. After release, btn_held=4'hF after exactly 10 cycles; a single event with evt_btn=0 is queued first.
- Glitch rejection: pulse btn_raw[2] high for 7 cycles, then low -> btn_held[2] never rises, no event. An 8+ cycle pulse gives exactly one event with evt_btn=2.
- Simultaneous press: btn_raw 0->4'b1010 with evt_ready=1 -> events evt_btn=1, then 3, two cycles apart; overrun=0.
- Backpressure/overrun: hold evt_ready=0, press button 0, release, press again -> first event stays presented, overrun=1. After evt_ready=1 only one event is seen.
- ncs gating: ncs=1, press button 3 -> btn_held[3]=1, no event. Set ncs=0 while still held -> no event (no new edge).
- GV_BTN_AUTOREPEAT_EN defined: hold button 1 for 100 cycles with evt_ready=1 -> events at press, +40, +56, +72, +88 cycles (relative to btn_held rise). None after release.
